// File: rtl/gpio_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : gpio_event_monitor
// Purpose  : Simulation/debug helper that watches a GPIO output bus. Every
//            change on the bus is time-stamped with a free-running cycle
//            counter and queued in a first-word-fall-through FIFO that is
//            drained over a valid/ready interface. Dropped events are counted,
//            and a sticky idle timeout flags that the bus has stopped moving.
// Ports    :
//   clk        in   1                 system clock
//   reset      in   1                 synchronous active-high reset
//   gpio_in    in   WIDTH             monitored bus (already synchronous)
//   clear      in   1                 soft clear of FIFO and status
//   evt_valid  out  1                 FIFO head holds an event
//   evt_ready  in   1                 consumer takes the head this cycle
//   evt_data   out  WIDTH             bus value of the head event
//   evt_time   out  TS_WIDTH          cycle count when head event was captured
//   evt_count  out  $clog2(DEPTH)+1   events currently stored
//   overflow   out  1                 sticky: at least one event dropped
//   drop_count out  16                dropped events, saturating
//   timeout    out  1                 sticky idle-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module gpio_event_monitor #(
  parameter int WIDTH    = 5,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32,
  parameter int TIMEOUT  = 5000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           gpio_in,
  input  logic                       clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [WIDTH-1:0]           evt_data,
  output logic [TS_WIDTH-1:0]        evt_time,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic                       timeout
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [TS_WIDTH-1:0] r_cycle_cnt;
  logic [WIDTH-1:0]    r_prev;
  logic [WIDTH-1:0]    r_mem_data [DEPTH];
  logic [TS_WIDTH-1:0] r_mem_time [DEPTH];
  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [c_AW:0]       r_wr_ptr;
  logic [c_AW:0]       r_rd_ptr;
  logic                r_overflow;
  logic [15:0]         r_drop_count;
  logic                r_timeout;

  logic                w_change;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [c_CW-1:0]     w_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  always_comb begin
    w_change = (gpio_in != r_prev);
    w_count  = r_wr_ptr - r_rd_ptr;
    w_empty  = (r_wr_ptr == r_rd_ptr);
    w_full   = (w_count == c_CW'(DEPTH));
    // clear overrides both FIFO operations in the same cycle.
    w_pop    = !w_empty && evt_ready && !clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_push   = w_change && !clear && (!w_full || w_pop);
    w_drop   = w_change && !clear && w_full && !w_pop;
  end

  // --------------------------------------------------------------------------
  // Free-running timestamp and previous-value register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_prev      <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      r_prev      <= gpio_in;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage (no reset needed; validity is tracked by the pointers)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_data[r_wr_ptr[c_AW-1:0]] <= gpio_in;
      r_mem_time[r_wr_ptr[c_AW-1:0]] <= r_cycle_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and overflow accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Idle timeout
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_timeout_en
      localparam int c_IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
      localparam logic [c_IW-1:0] c_TO_MAX  = c_IW'(TIMEOUT);
      localparam logic [c_IW-1:0] c_TO_LAST = c_IW'(TIMEOUT - 1);

      logic [c_IW-1:0] r_idle_cnt;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          r_idle_cnt <= '0;
          r_timeout  <= 1'b0;
        end else if (w_change) begin
          // A change restarts the idle window but does not clear the flag.
          r_idle_cnt <= '0;
        end else begin
          if (r_idle_cnt == c_TO_LAST) begin
            r_timeout <= 1'b1;
          end
          if (r_idle_cnt != c_TO_MAX) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
      end
    end else begin : g_timeout_dis
      always_ff @(posedge clk) begin
        r_timeout <= 1'b0;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    evt_valid  = !w_empty;
    evt_data   = r_mem_data[r_rd_ptr[c_AW-1:0]];
    evt_time   = r_mem_time[r_rd_ptr[c_AW-1:0]];
    evt_count  = w_count;
    overflow   = r_overflow;
    drop_count = r_drop_count;
    timeout    = r_timeout;
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_event_monitor
// Purpose  : Self-checking bench for gpio_event_monitor (DEPTH=4,
//            TIMEOUT=10). Table-driven vectors, hand-written corner
//            sequences and random stimulus against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_event_monitor;

  localparam int WIDTH    = 5;
  localparam int DEPTH    = 4;
  localparam int TS_WIDTH = 32;
  localparam int TIMEOUT  = 10;

  logic                  clk;
  logic                  reset;
  logic [WIDTH-1:0]      gpio_in;
  logic                  clear;
  logic                  evt_valid;
  logic                  evt_ready;
  logic [WIDTH-1:0]      evt_data;
  logic [TS_WIDTH-1:0]   evt_time;
  logic [$clog2(DEPTH):0] evt_count;
  logic                  overflow;
  logic [15:0]           drop_count;
  logic                  timeout;

  gpio_event_monitor #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .gpio_in(gpio_in), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_time(evt_time), .evt_count(evt_count), .overflow(overflow),
    .drop_count(drop_count), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: events held in a queue, status as plain integers.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0]    d;
    logic [TS_WIDTH-1:0] t;
  } ev_t;

  ev_t                 mq[$];
  logic [TS_WIDTH-1:0] m_cyc;
  logic [WIDTH-1:0]    m_prev;
  bit                  m_ovf;
  int                  m_drops;
  int                  m_idle;
  bit                  m_to;

  task automatic model_step(input logic r, input logic [WIDTH-1:0] g,
                            input logic c, input logic rd);
    bit chg;
    ev_t e;
    if (r) begin
      mq.delete();
      m_cyc = 0; m_prev = 0; m_ovf = 0; m_drops = 0; m_idle = 0; m_to = 0;
      return;
    end
    chg = (g != m_prev);
    if (c) begin
      mq.delete();
      m_ovf = 0; m_drops = 0; m_idle = 0; m_to = 0;
    end else begin
      if (mq.size() > 0 && rd) void'(mq.pop_front());
      if (chg) begin
        if (mq.size() < DEPTH) begin
          e.d = g; e.t = m_cyc;
          mq.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (chg) m_idle = 0;
      else begin
        if (TIMEOUT > 0 && m_idle == TIMEOUT - 1) m_to = 1;
        if (m_idle < TIMEOUT) m_idle++;
      end
    end
    m_prev = g;
    m_cyc  = m_cyc + 1;
  endtask

  task automatic compare_model();
    chk("m_evt_valid", evt_valid, mq.size() > 0);
    chk("m_evt_count", evt_count, mq.size());
    if (mq.size() > 0) begin
      chk("m_evt_data", evt_data, mq[0].d);
      chk("m_evt_time", evt_time, mq[0].t);
    end
    chk("m_overflow", overflow, m_ovf);
    chk("m_drop_count", drop_count, m_drops);
    chk("m_timeout", timeout, m_to);
  endtask

  // Drive one cycle, advance the model at the edge, sample 1 ns later.
  task automatic cyc(input logic r, input logic [WIDTH-1:0] g,
                     input logic c, input logic rd);
    reset = r; gpio_in = g; clear = c; evt_ready = rd;
    @(posedge clk);
    model_step(r, g, c, rd);
    #1;
    compare_model();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic             r, c, rd;
    logic [WIDTH-1:0] g;
    logic             ev;
    int               ec;
    logic [WIDTH-1:0] ed;
    int               et;
    logic             eo;
    int               edr;
    logic             eto;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [WIDTH-1:0] g,
                              input logic c, input logic rd, input logic ev,
                              input int ec, input logic [WIDTH-1:0] ed,
                              input int et, input logic eo, input int edr,
                              input logic eto);
    vec_t v;
    v.r = r; v.g = g; v.c = c; v.rd = rd; v.ev = ev; v.ec = ec;
    v.ed = ed; v.et = et; v.eo = eo; v.edr = edr; v.eto = eto;
    tbl.push_back(v);
  endfunction

  logic [WIDTH-1:0] hold;

  initial begin
    reset = 1'b1; gpio_in = '0; clear = 1'b0; evt_ready = 1'b0;

    // Initial capture: change on post-reset cycle 3.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 3, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 3, 0, 0, 0);
    // Reset mid-operation drops the stored event; then overflow with 6 changes.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 2, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    add(0, 3, 0, 0, 1, 3, 1, 0, 0, 0, 0);
    add(0, 4, 0, 0, 1, 4, 1, 0, 0, 0, 0);
    add(0, 5, 0, 0, 1, 4, 1, 0, 1, 1, 0);
    add(0, 6, 0, 0, 1, 4, 1, 0, 1, 2, 0);
    add(0, 6, 0, 1, 1, 3, 2, 1, 1, 2, 0);
    add(0, 6, 0, 1, 1, 2, 3, 2, 1, 2, 0);
    add(0, 6, 0, 1, 1, 1, 4, 3, 1, 2, 0);
    add(0, 6, 0, 1, 0, 0, 0, 0, 1, 2, 0);
    // Non-zero bus held through reset.
    add(1, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 21, 0, 0, 1, 1, 21, 0, 0, 0, 0);
    add(0, 21, 0, 0, 1, 1, 21, 0, 0, 0, 0);
    add(0, 21, 0, 0, 1, 1, 21, 0, 0, 0, 0);
    // Full FIFO with simultaneous push and pop.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 2, 0, 0, 1, 2, 1, 0, 0, 0, 0);
    add(0, 3, 0, 0, 1, 3, 1, 0, 0, 0, 0);
    add(0, 4, 0, 0, 1, 4, 1, 0, 0, 0, 0);
    add(0, 7, 0, 1, 1, 4, 2, 1, 0, 0, 0);
    add(0, 7, 0, 1, 1, 3, 3, 2, 0, 0, 0);
    add(0, 7, 0, 1, 1, 2, 4, 3, 0, 0, 0);
    add(0, 7, 0, 1, 1, 1, 7, 4, 0, 0, 0);
    add(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].g, tbl[i].c, tbl[i].rd);
      chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_count", i), evt_count, tbl[i].ec);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), evt_data, tbl[i].ed);
        chk($sformatf("tbl%0d_time", i), evt_time, tbl[i].et);
      end
      chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].eo);
      chk($sformatf("tbl%0d_drops", i), drop_count, tbl[i].edr);
      chk($sformatf("tbl%0d_timeout", i), timeout, tbl[i].eto);
    end

    // Timeout: 10 idle edges after the last change, sticky, cleared by clear.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0, 0);
      if (i == 9)  chk("to_before", timeout, 1'b0);
      if (i == 10) chk("to_set", timeout, 1'b1);
    end
    cyc(0, 2, 0, 0);
    chk("to_sticky", timeout, 1'b1);
    cyc(0, 2, 1, 0);
    chk("to_clear", timeout, 1'b0);

    // Clear colliding with a change while 2 events are queued.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 2, 0, 0);
    chk("clr_pre_count", evt_count, 2);
    cyc(0, 3, 1, 0);
    chk("clr_valid", evt_valid, 1'b0);
    chk("clr_count", evt_count, 0);
    chk("clr_drops", drop_count, 0);
    cyc(0, 3, 0, 0);
    chk("clr_noretrig_valid", evt_valid, 1'b0);
    chk("clr_noretrig_count", evt_count, 0);

    // Random stimulus against the model.
    hold = 3;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) hold = WIDTH'($urandom);
      cyc($urandom_range(0, 299) == 0, hold,
          $urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_event_monitor.md
Name: gpio_event_monitor

Overview:
- Simulation/debug helper that watches a parametrised-width output bus from the SOC (default: the 5-bit LEDS bus).
- Detects every change on the bus and timestamps it with a free-running cycle counter.
- Buffers change events in a FIFO with a valid/ready drain interface.
- Flags FIFO overflow and raises an idle-timeout when the bus stops changing, so benches can end runs on a condition instead of a fixed delay.

Parameters:
- WIDTH, 5: monitored bus width.
- DEPTH, 16: event FIFO depth; power of two, >=2.
- TS_WIDTH, 32: timestamp/cycle-counter width.
- TIMEOUT, 5000: idle cycles before timeout asserts; 0 disables timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- gpio_in  in  WIDTH  monitored bus; synchronous to clk, no synchroniser inside.
- clear  in  1  synchronous soft clear of FIFO and status.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head this cycle.
- evt_data  out  WIDTH  bus value of the head event.
- evt_time  out  TS_WIDTH  cycle-counter value when the head event was captured.
- evt_count  out  $clog2(DEPTH)+1  number of events currently stored.
- overflow  out  1  sticky: at least one event dropped.
- drop_count  out  16  dropped events, saturating at 16'hFFFF.
- timeout  out  1  sticky idle-timeout flag.

Behaviour:
- Reset: cycle_cnt=0, prev=0, FIFO empty, evt_valid=0, evt_count=0, overflow=0, drop_count=0, timeout=0, idle_cnt=0. evt_data and evt_time are don't-care while evt_valid=0.
- cycle_cnt: increments every non-reset cycle and wraps modulo 2^TS_WIDTH. clear does not affect it.
- Change detect:
  - change = (gpio_in != prev).
  - prev <= gpio_in every non-reset cycle, including during clear.
  - Because prev resets to 0, a non-zero bus on the first post-reset cycle produces an event with timestamp 0.
- Push: on change, {gpio_in, cycle_cnt} is written at that clock edge. evt_valid rises the following cycle (1-cycle latency, first-word-fall-through).
- Pop: occurs on evt_valid && evt_ready. The head advances at the edge.
- Simultaneous push and pop: both take effect, including when the FIFO is full; evt_count is unchanged.
- Full with push and no pop: the event is dropped, overflow<=1, and drop_count increments (saturating). FIFO contents are unchanged.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- idle_cnt and timeout:
  - idle_cnt <= 0 on change. Otherwise idle_cnt increments, saturating at TIMEOUT.
  - timeout <= 1 on the edge where idle_cnt == TIMEOUT-1 and there is no change.
  - timeout is sticky: a later change resets idle_cnt but not timeout.
  - With TIMEOUT=0, timeout stays 0.
- clear:
  - Empties the FIFO and zeroes overflow, drop_count, timeout and idle_cnt.
  - Has priority over a push or pop in the same cycle; a coincident change is discarded and not counted as dropped.
- reset has priority over clear. Asserting reset mid-operation discards all stored events immediately.

Test Plan:
- Initial capture: DEPTH=4, TIMEOUT=10. Release reset with gpio_in=0, set gpio_in=5'b00001 on post-reset cycle 3 -> one event with evt_data=00001, evt_time=3; evt_valid high on cycle 4; evt_count=1.
- Non-zero at reset: hold gpio_in=5'b10101 through reset -> event evt_data=10101, evt_time=0. No further events while the bus holds.
- Overflow: evt_ready=0, 6 distinct changes on consecutive cycles -> evt_count=4, overflow=1, drop_count=2. Draining yields the first 4 values in order with increasing timestamps.
- Full with simultaneous push and pop: FIFO full, evt_ready=1 plus a change in the same cycle -> evt_count stays 4, overflow stays 0, the new event appears last.
- Timeout: hold the bus for 10 cycles after the last change -> timeout=1 after the 10th idle edge. A later change leaves timeout=1; a clear pulse drops it to 0.
- Clear collision: clear=1 in the same cycle as a change with 2 events queued -> next cycle evt_valid=0, evt_count=0, drop_count=0. The bus value at that point does not re-trigger an event.
